// File: rtl/operand_sequencer_pkg.sv
// Shared definitions for the MAC operand-entry stage: FSM encoding and debounce defaults.
package operand_sequencer_pkg;
  typedef enum logic [2:0] {
    ST_A    = 3'd0,
    ST_B    = 3'd1,
    ST_C    = 3'd2,
    ST_D    = 3'd3,
    ST_SEND = 3'd4
  } seq_state_t;

  localparam int DEBOUNCE_CYC_BOARD = 500000;
  localparam int DEBOUNCE_CYC_SIM   = 16;
endpackage

// File: rtl/operand_sequencer_key_debounce.sv
// Key conditioner: 2-flop synchroniser, hold-time debounce, registered rising-edge pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_rise_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1, sync2, level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1          <= 1'b0;
      sync2          <= 1'b0;
      cnt            <= '0;
      key_level      <= 1'b0;
      level_q        <= 1'b0;
      key_rise_pulse <= 1'b0;
    end else begin
      sync1   <= key_raw;
      sync2   <= sync1;
      level_q <= key_level;
      key_rise_pulse <= key_level & ~level_q;
      // Any return of the synchronised level to the accepted level restarts the hold count.
      if (sync2 == key_level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        cnt       <= '0;
        key_level <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/operand_sequencer.sv
// Collects A, B, C, D from one switch bank on debounced load presses and offers them to the MAC.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_SIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              load_key,
  input  logic              clear_key,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [DATA_W-1:0] c_out,
  output logic [DATA_W-1:0] d_out,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [1:0]        stage,
  output logic              busy
);
  seq_state_t state;
  logic       load_level, load_pulse, clear_level, clear_pulse;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_load_db (
    .clk(clk), .rst(rst), .key_raw(load_key),
    .key_level(load_level), .key_rise_pulse(load_pulse)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear_db (
    .clk(clk), .rst(rst), .key_raw(clear_key),
    .key_level(clear_level), .key_rise_pulse(clear_pulse)
  );

  logic unused_levels;
  assign unused_levels = load_level ^ clear_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_A;
      a_out    <= '0;
      b_out    <= '0;
      c_out    <= '0;
      d_out    <= '0;
      op_valid <= 1'b0;
      stage    <= 2'd0;
      busy     <= 1'b0;
    end else if (clear_pulse) begin
      state    <= ST_A;
      a_out    <= '0;
      b_out    <= '0;
      c_out    <= '0;
      d_out    <= '0;
      op_valid <= 1'b0;
      stage    <= 2'd0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_A: if (load_pulse) begin
          a_out <= sw_data; state <= ST_B; stage <= 2'd1; busy <= 1'b1;
        end
        ST_B: if (load_pulse) begin
          b_out <= sw_data; state <= ST_C; stage <= 2'd2;
        end
        ST_C: if (load_pulse) begin
          c_out <= sw_data; state <= ST_D; stage <= 2'd3;
        end
        ST_D: if (load_pulse) begin
          d_out <= sw_data; state <= ST_SEND; op_valid <= 1'b1;
        end
        // Loads are ignored while offering; the set stays frozen until accepted.
        ST_SEND: if (op_ready) begin
          state <= ST_A; op_valid <= 1'b0; stage <= 2'd0; busy <= 1'b0;
        end
        default: begin
          state <= ST_A; op_valid <= 1'b0; stage <= 2'd0; busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
